// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } div_flags_t;

  localparam int DIV_W_DEFAULT = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int M = 4
) (
  input  logic [M-1:0] p,
  input  logic         msb,
  input  logic [M-1:0] b,
  output logic [M-1:0] p_nxt,
  output logic         qbit
);

  logic [M:0]   trial;
  logic [M+1:0] diff;

  // The partial remainder is always below the divisor, so {p, msb} < 2*b and the
  // difference fits back into M bits; the extra top bit of diff is the borrow.
  always_comb begin
    trial = {p, msb};
    diff  = {1'b0, trial} - {2'b00, b};
    qbit  = ~diff[M+1];
    p_nxt = qbit ? diff[M-1:0] : trial[M-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
module div_seq
  import div_pkg::*;
#(
  parameter int M = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] Q,
  output logic [M-1:0] R,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z
);

  localparam int CW = $clog2(M + 1);

  div_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [M-1:0]  dvd_q, dvs_q, rem_q;
  logic [M-1:0]  q_q, r_q;
  div_flags_t    flags_q;

  logic [M-1:0]  rem_nxt, q_nxt;
  logic          qbit;
  logic          accept, last_step;
  div_flags_t    flags_norm, flags_dz;

  div_step #(.M(M)) u_step (
    .p     (rem_q),
    .msb   (dvd_q[M-1]),
    .b     (dvs_q),
    .p_nxt (rem_nxt),
    .qbit  (qbit)
  );

  assign accept    = (state_q == IDLE) && start;
  assign last_step = (cnt_q == CW'(M - 1));
  assign q_nxt     = {dvd_q[M-2:0], qbit};

  always_comb begin
    flags_norm   = '0;
    flags_norm.c = (rem_nxt != '0);
    flags_norm.n = q_nxt[M-1];
    flags_norm.v = 1'b0;
    flags_norm.z = (q_nxt == '0);
    flags_dz     = '0;
    flags_dz.c   = (A != '0);
    flags_dz.n   = 1'b1;
    flags_dz.v   = 1'b1;
    flags_dz.z   = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (B == '0) ? DONE : ITER;
      ITER:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are written only at a completion edge (or at accept for divide-by-zero)
  // so they hold through IDLE until the next operation finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dvd_q <= A;
        dvs_q <= B;
        rem_q <= '0;
        cnt_q <= '0;
        if (B == '0) begin
          q_q     <= '1;
          r_q     <= A;
          flags_q <= flags_dz;
        end
      end else if (state_q == ITER) begin
        dvd_q <= q_nxt;
        rem_q <= rem_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last_step) begin
          q_q     <= q_nxt;
          r_q     <= rem_nxt;
          flags_q <= flags_norm;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign C    = flags_q.c;
  assign N    = flags_q.n;
  assign V    = flags_q.v;
  assign Z    = flags_q.z;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus a shuffled sweep of all operand pairs.
module tb_div_seq;

  localparam int M = 4;
  localparam int ONES = (1 << M) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] A = '0;
  logic [M-1:0] B = '0;
  logic         busy, done, C, N, V, Z;
  logic [M-1:0] Q, R;

  div_seq #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .C     (C),
    .N     (N),
    .V     (V),
    .Z     (Z)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain division with the defined divide-by-zero result.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int c,
                                  output int n, output int v, output int z);
    if (b == 0) begin
      q = ONES; r = a; v = 1;
    end else begin
      q = a / b; r = a % b; v = 0;
    end
    c = (r != 0) ? 1 : 0;
    n = (q >> (M - 1)) & 1;
    z = (q == 0) ? 1 : 0;
  endfunction

  // Timing model: an accepted operation finishes lat edges after acceptance
  // (M normally, 0 for divide-by-zero), done shows in the following cycle,
  // and busy drops one edge later. Starts are ignored while busy.
  bit m_busy = 0;
  int m_age = 0, m_lat = 0;
  int m_q = 0, m_r = 0, m_c = 0, m_n = 0, m_v = 0, m_z = 0;
  int p_q, p_r, p_c, p_n, p_v, p_z;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_lat = 0;
      m_q = 0; m_r = 0; m_c = 0; m_n = 0; m_v = 0; m_z = 0;
    end else if (m_busy) begin
      m_age++;
      if (m_age == m_lat) begin
        m_q = p_q; m_r = p_r; m_c = p_c; m_n = p_n; m_v = p_v; m_z = p_z;
      end else if (m_age > m_lat) begin
        m_busy = 0;
      end
    end else if (start) begin
      ref_div(int'(A), int'(B), p_q, p_r, p_c, p_n, p_v, p_z);
      m_busy = 1;
      m_age  = 0;
      m_lat  = (B == '0) ? 0 : M;
      if (m_lat == 0) begin
        m_q = p_q; m_r = p_r; m_c = p_c; m_n = p_n; m_v = p_v; m_z = p_z;
      end
    end
  end

  bit   chk_en = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), (m_busy && m_age == m_lat) ? 1 : 0);
      check("Q", int'(Q), m_q);
      check("R", int'(R), m_r);
      check("C", int'(C), m_c);
      check("N", int'(N), m_n);
      check("V", int'(V), m_v);
      check("Z", int'(Z), m_z);
      check("done_consecutive", int'(prev_done & done), 0);
      prev_done = done;
    end
  end

  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int ec, input int en, input int ev, input int ez,
                        input string tag);
    int lat;
    int k;
    bit seen;
    lat  = (b == 0) ? 0 : M;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; A = M'(a); B = M'(b);
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k <= M + 4; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, " latency"}, seen ? k : -1, lat);
    check({tag, " Q"}, int'(Q), eq);
    check({tag, " R"}, int'(R), er);
    check({tag, " C"}, int'(C), ec);
    check({tag, " N"}, int'(N), en);
    check({tag, " V"}, int'(V), ev);
    check({tag, " Z"}, int'(Z), ez);
    @(negedge clk);
    check({tag, " busy_after_done"}, int'(busy), 0);
    check({tag, " done_after_done"}, int'(done), 0);
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
  endtask

  int perm[256];

  initial begin
    int dcount;
    int eq, er, ec, en, ev, ez;

    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset Q", int'(Q), 0);
    check("reset R", int'(R), 0);
    check("reset flags", int'({C, N, V, Z}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(13, 3, 4, 1, 1, 0, 0, 0, "13/3");
    run_op(15, 1, 15, 0, 0, 1, 0, 0, "15/1");
    run_op(2, 7, 0, 2, 1, 0, 0, 1, "2/7");
    run_op(9, 0, 15, 9, 1, 1, 1, 0, "9/0");
    run_op(0, 0, 15, 0, 0, 1, 1, 0, "0/0");

    // A start raised mid-operation must be dropped, not queued.
    @(posedge clk); #1;
    start = 1'b1; A = 4'd13; B = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; A = 4'd6; B = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ignored_start done_count", dcount, 1);
    check("ignored_start Q", int'(Q), 4);
    check("ignored_start R", int'(R), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold Q", int'(Q), 4);
      check("hold R", int'(R), 1);
      check("hold done", int'(done), 0);
    end

    // Reset sampled at the second iteration edge aborts the operation.
    @(posedge clk); #1;
    start = 1'b1; A = 4'd13; B = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset Q", int'(Q), 0);
    check("midreset R", int'(R), 0);
    check("midreset flags", int'({C, N, V, Z}), 0);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midreset no_done", dcount, 0);
    run_op(7, 2, 3, 1, 1, 0, 0, 0, "7/2");

    // All operand pairs in shuffled order.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      ref_div(perm[i] >> 4, perm[i] & 15, eq, er, ec, en, ev, ez);
      run_op(perm[i] >> 4, perm[i] & 15, eq, er, ec, en, ev, ez, "sweep");
    end

    // start held high with changing random operands: back-to-back accepts.
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      A = M'($urandom);
      B = (k % 5 == 0) ? '0 : M'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
    @(negedge clk);
    check("final idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
